// File: rtl/deserializer_pkg.sv
// deserializer_pkg
//   Shared widths and the buffered word type for the serial-to-parallel
//   deserializer. The default DATA_W of 16 sets the size of the stored word.
//   MOD_W is the width of the valid-bit count. A count of DATA_W is encoded as 0.
package deserializer_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int MOD_W      = $clog2(DATA_W_DEF);

  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic [MOD_W-1:0]      mod;
  } deser_word_t;

endpackage

// File: rtl/deser_fifo.sv
// deser_fifo
//   Synchronous FIFO of deser_word_t entries. The head entry is read straight
//   from the storage registers, so the outputs depend on flops only.
//   A push that arrives together with a pop on a full FIFO is accepted.
// Ports:
//   i_clk, i_rst : clock, async active-high reset
//   i_push/i_word: write request and data (dropped when full without pop)
//   i_pop        : remove head (ignored when empty)
//   o_full/o_empty, o_head : status and current head entry
module deser_fifo
  import deserializer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_push,
  input  deser_word_t i_word,
  input  logic        i_pop,
  output logic        o_full,
  output logic        o_empty,
  output deser_word_t o_head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  deser_word_t         r_mem [DEPTH];
  logic [PW-1:0]       r_wr;
  logic [PW-1:0]       r_rd;
  logic [CW-1:0]       r_count;

  logic w_do_pop;
  logic w_do_push;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_head    = r_mem[r_rd];
  assign w_do_pop  = i_pop && !o_empty;
  // On a full FIFO the slot being vacated by the pop is the write slot.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr] <= i_word;
        r_wr        <= (r_wr == PW'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
      end
      if (w_do_pop)
        r_rd <= (r_rd == PW'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/deserializer.sv
// deserializer
//   Rebuilds parallel words from an MSB-first serial stream. A word is pushed
//   when its DATA_W-th bit arrives, or when the stream goes idle while a word
//   is partly filled (partial word, left-aligned, mod = bit count). Words are
//   buffered in deser_fifo and presented over a valid/ready handshake.
// Ports:
//   clk_i, rst_i                   : clock, async active-high reset
//   ser_data_i, ser_data_val_i     : serial bit and its qualifier
//   deser_data_o, deser_data_mod_o : FIFO head word and valid-bit count
//   deser_data_val_o               : head valid
//   deser_ready_i                  : consumer accepts the head
//   overflow_o                     : one-cycle pulse when a completed word was dropped
module deserializer
  import deserializer_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,  // must match the package word type
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ser_data_i,
  input  logic              ser_data_val_i,
  output logic [DATA_W-1:0] deser_data_o,
  output logic [MOD_W-1:0]  deser_data_mod_o,
  output logic              deser_data_val_o,
  input  logic              deser_ready_i,
  output logic              overflow_o
);

  logic [DATA_W-1:0] r_shift;
  logic [MOD_W-1:0]  r_cnt;     // bits collected so far; 0 means IDLE
  logic              r_overflow;

  logic [DATA_W-1:0] w_shift_bit;
  logic [MOD_W-1:0]  w_idx;
  logic              w_last;
  logic              w_flush;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  deser_word_t       w_push_word;
  deser_word_t       w_head;

  assign w_idx = MOD_W'(DATA_W - 1) - r_cnt;

  // Current shift contents with the incoming bit placed at its MSB-first slot.
  always_comb begin
    w_shift_bit        = r_shift;
    w_shift_bit[w_idx] = ser_data_i;
  end

  assign w_last  = ser_data_val_i && (r_cnt == MOD_W'(DATA_W - 1));
  assign w_flush = !ser_data_val_i && (r_cnt != '0);
  assign w_push  = w_last || w_flush;
  assign w_pop   = !w_empty && deser_ready_i;

  // A full word reports mod 0; a flushed word reports its bit count.
  assign w_push_word.data = w_last ? w_shift_bit : r_shift;
  assign w_push_word.mod  = w_last ? '0 : r_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_shift    <= '0;
      r_cnt      <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_push && w_full && !w_pop;
      if (w_push) begin
        r_shift <= '0;
        r_cnt   <= '0;
      end else if (ser_data_val_i) begin
        r_shift <= w_shift_bit;
        r_cnt   <= r_cnt + 1'b1;
      end
    end
  end

  deser_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_push  (w_push),
    .i_word  (w_push_word),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  assign deser_data_o     = w_head.data;
  assign deser_data_mod_o = w_head.mod;
  assign deser_data_val_o = !w_empty;
  assign overflow_o       = r_overflow;

endmodule

// File: tb/tb_deserializer.sv
module tb_deserializer;

  localparam int DW    = 16;
  localparam int MW    = 4;
  localparam int DEPTH = 2;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          ser_data_i;
  logic          ser_data_val_i;
  logic [DW-1:0] deser_data_o;
  logic [MW-1:0] deser_data_mod_o;
  logic          deser_data_val_o;
  logic          deser_ready_i;
  logic          overflow_o;

  deserializer #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .ser_data_i       (ser_data_i),
    .ser_data_val_i   (ser_data_val_i),
    .deser_data_o     (deser_data_o),
    .deser_data_mod_o (deser_data_mod_o),
    .deser_data_val_o (deser_data_val_o),
    .deser_ready_i    (deser_ready_i),
    .overflow_o       (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [DW-1:0] d;
    logic [MW-1:0] m;
  } word_t;

  // Reference model: collected bits of the word in progress, and the
  // words the consumer should see, oldest first.
  bit    bits[$];
  word_t exp_q[$];
  logic  exp_ovf;
  int    ncmp = 0;
  int    nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic word_t pack_bits();
    word_t w;
    w.d = '0;
    for (int i = 0; i < bits.size(); i++) w.d[DW-1-i] = bits[i];
    w.m = MW'(bits.size() % DW);
    return w;
  endfunction

  task automatic model_edge(input logic v, input logic d, input logic r);
    bit    pop;
    bit    push;
    word_t w;
    pop  = (exp_q.size() > 0) && r;
    push = 0;
    if (v) begin
      bits.push_back(d);
      if (bits.size() == DW) begin
        w = pack_bits(); push = 1; bits.delete();
      end
    end else if (bits.size() > 0) begin
      w = pack_bits(); push = 1; bits.delete();
    end
    if (pop) void'(exp_q.pop_front());
    exp_ovf = 1'b0;
    if (push) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(w);
      else exp_ovf = 1'b1;
    end
  endtask

  task automatic check_outputs();
    chk("val", 32'(deser_data_val_o), 32'(exp_q.size() > 0));
    chk("ovf", 32'(overflow_o), 32'(exp_ovf));
    if (exp_q.size() > 0) begin
      chk("data", 32'(deser_data_o), 32'(exp_q[0].d));
      chk("mod", 32'(deser_data_mod_o), 32'(exp_q[0].m));
    end
  endtask

  task automatic step(input logic v, input logic d, input logic r);
    ser_data_val_i = v;
    ser_data_i     = d;
    deser_ready_i  = r;
    @(posedge clk_i);
    model_edge(v, d, r);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    ser_data_val_i = 1'b0;
    ser_data_i     = 1'b0;
    rst_i          = 1'b1;
    #1;
    chk("rst_val", 32'(deser_data_val_o), 32'd0);
    chk("rst_data", 32'(deser_data_o), 32'd0);
    chk("rst_mod", 32'(deser_data_mod_o), 32'd0);
    chk("rst_ovf", 32'(overflow_o), 32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    bits.delete();
    exp_q.delete();
    exp_ovf = 1'b0;
  endtask

  task automatic send_bits(input logic [DW-1:0] w, input int n, input logic r);
    for (int i = 0; i < n; i++) step(1'b1, w[DW-1-i], r);
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, r);
  endtask

  initial begin
    rst_i          = 1'b1;
    ser_data_i     = 1'b0;
    ser_data_val_i = 1'b0;
    deser_ready_i  = 1'b0;
    exp_ovf        = 1'b0;
    #2;
    do_reset();

    // Reset mid-word, then a clean word.
    send_bits(16'h5A00, 5, 1'b1);
    do_reset();
    send_bits(16'hA5C3, 16, 1'b1);
    idle(3, 1'b1);

    // Single full word, then back-to-back words.
    send_bits(16'hBEEF, 16, 1'b1);
    idle(2, 1'b1);
    send_bits(16'h1234, 16, 1'b1);
    send_bits(16'hFFFF, 16, 1'b1);
    idle(3, 1'b1);

    // Partial words: 10110 then 111.
    send_bits(16'hB000, 5, 1'b1);
    idle(2, 1'b1);
    send_bits(16'hE000, 3, 1'b1);
    idle(2, 1'b1);
    send_bits(16'hC000, 1, 1'b1);
    idle(1, 1'b1);
    send_bits(16'h4000, 2, 1'b1);
    idle(2, 1'b1);

    // Backpressure: third word dropped with an overflow pulse.
    send_bits(16'h0001, 16, 1'b0);
    send_bits(16'h0002, 16, 1'b0);
    send_bits(16'h0003, 16, 1'b0);
    idle(2, 1'b0);
    idle(4, 1'b1);

    // Full FIFO with ready rising on the completing bit: nothing lost.
    do_reset();
    send_bits(16'h0001, 16, 1'b0);
    send_bits(16'h0002, 16, 1'b0);
    send_bits(16'h0003, 15, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    idle(4, 1'b1);

    // Randomized traffic with random backpressure and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      step(($urandom_range(0, 4) != 0), 1'($urandom), ($urandom_range(0, 9) < 6));
    end
    idle(4, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
